// File: rtl/meter_update_sched.sv
// meter_update_sched
// Update scheduler for the parking-meter time register. It captures one-cycle
// requests from the tick, the four add buttons and the two preset loads, and
// applies one operation at a time to the shared count register.
//
// Ports:
//   clk        system clock, all state on posedge
//   reset      asynchronous, active-high; clears all state
//   tick       1 Hz strobe, requests a decrement
//   add_req    bit i requests +AMTi
//   load10     request count = LOAD_A
//   load205    request count = LOAD_B (wins over load10)
//   count      remaining time, binary, 0..MAX_COUNT
//   flash      registered, count < FLASH_LIMIT
//   expired    registered, count == 0
//   busy       an operation is being written this cycle
//   req_drop   sticky: an add strobe was lost to pending saturation
//   tick_lost  sticky: a tick arrived while one was still pending
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | waiting; grants the highest-priority pending request
// S_EXEC | writes count/flash/expired from the latched operation
module meter_update_sched #(
  parameter int MAX_COUNT   = 9999,
  parameter int FLASH_LIMIT = 200,
  parameter int AMT0        = 10,
  parameter int AMT1        = 180,
  parameter int AMT2        = 200,
  parameter int AMT3        = 550,
  parameter int LOAD_A      = 10,
  parameter int LOAD_B      = 205,
  parameter int PEND_MAX    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [3:0]  add_req,
  input  logic        load10,
  input  logic        load205,
  output logic [13:0] count,
  output logic        flash,
  output logic        expired,
  output logic        busy,
  output logic        req_drop,
  output logic        tick_lost
);

  typedef enum logic {S_IDLE, S_EXEC} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_TICK, OP_ADD} op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [13:0] operand_q, operand_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  pend_q [4];
  logic [1:0]  pend_d [4];
  logic        tick_q, tick_d;
  logic        load_q, load_d;
  logic        load_sel_q, load_sel_d;
  logic        drop_set, lost_set;

  logic        grant_load, grant_tick, grant_add, found;
  logic [1:0]  add_idx, idx;
  logic [14:0] sum;
  logic [13:0] new_count;

  function automatic logic [13:0] amt(input logic [1:0] i);
    case (i)
      2'd0:    amt = 14'(AMT0);
      2'd1:    amt = 14'(AMT1);
      2'd2:    amt = 14'(AMT2);
      default: amt = 14'(AMT3);
    endcase
  endfunction

  assign busy = (state_q == S_EXEC);

  // Grant selection: load > tick > round-robin adds starting at ptr_q.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    operand_d  = operand_q;
    ptr_d      = ptr_q;
    grant_load = 1'b0;
    grant_tick = 1'b0;
    grant_add  = 1'b0;
    found      = 1'b0;
    add_idx    = ptr_q;
    idx        = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (load_q) begin
          grant_load = 1'b1;
          op_d       = OP_LOAD;
          operand_d  = load_sel_q ? 14'(LOAD_B) : 14'(LOAD_A);
          state_d    = S_EXEC;
        end else if (tick_q) begin
          grant_tick = 1'b1;
          op_d       = OP_TICK;
          operand_d  = 14'd0;
          state_d    = S_EXEC;
        end else begin
          for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && pend_q[idx] != 2'd0) begin
              found   = 1'b1;
              add_idx = idx;
            end
          end
          if (found) begin
            grant_add = 1'b1;
            op_d      = OP_ADD;
            operand_d = amt(add_idx);
            ptr_d     = add_idx + 2'd1;
            state_d   = S_EXEC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending bookkeeping. A consume and a capture on the same edge cancel, and
  // a load grant wipes older requests but keeps captures from that edge.
  always_comb begin
    drop_set = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic       consume;
      logic [1:0] base;
      consume = grant_add && (add_idx == 2'(i));
      base    = grant_load ? 2'd0 : pend_q[i] - {1'b0, consume};
      if (add_req[i]) begin
        if (!grant_load && !consume && pend_q[i] == 2'(PEND_MAX)) begin
          drop_set = 1'b1;
        end else begin
          base = base + 2'd1;
        end
      end
      pend_d[i] = base;
    end
    tick_d   = (tick_q && !grant_tick && !grant_load) || tick;
    lost_set = tick && tick_q && !grant_tick && !grant_load;
    load_d   = (load_q && !grant_load) || load10 || load205;
    if (load205)
      load_sel_d = 1'b1;
    else if (load10 && !(load_q && !grant_load))
      load_sel_d = 1'b0;
    else
      load_sel_d = load_sel_q;
  end

  // Single saturating add/subtract path for the EXEC write.
  always_comb begin
    sum = {1'b0, count} + {1'b0, operand_q};
    case (op_q)
      OP_LOAD: new_count = operand_q;
      OP_TICK: new_count = (count == 14'd0) ? 14'd0 : count - 14'd1;
      default: new_count = (sum > 15'(MAX_COUNT)) ? 14'(MAX_COUNT) : sum[13:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_LOAD;
      operand_q  <= 14'd0;
      ptr_q      <= 2'd0;
      for (int i = 0; i < 4; i++) pend_q[i] <= 2'd0;
      tick_q     <= 1'b0;
      load_q     <= 1'b0;
      load_sel_q <= 1'b0;
      req_drop   <= 1'b0;
      tick_lost  <= 1'b0;
      count      <= 14'd0;
      flash      <= 1'b1;
      expired    <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      operand_q  <= operand_d;
      ptr_q      <= ptr_d;
      for (int i = 0; i < 4; i++) pend_q[i] <= pend_d[i];
      tick_q     <= tick_d;
      load_q     <= load_d;
      load_sel_q <= load_sel_d;
      if (drop_set) req_drop  <= 1'b1;
      if (lost_set) tick_lost <= 1'b1;
      if (state_q == S_EXEC) begin
        count   <= new_count;
        flash   <= (new_count < 14'(FLASH_LIMIT));
        expired <= (new_count == 14'd0);
      end
    end
  end

endmodule

// File: tb/tb_meter_update_sched.sv
module tb_meter_update_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [3:0]  add_req = 4'd0;
  logic        load10 = 1'b0;
  logic        load205 = 1'b0;
  logic [13:0] count;
  logic        flash, expired, busy, req_drop, tick_lost;

  int errors = 0;
  int checks = 0;

  meter_update_sched dut (
    .clk(clk), .reset(reset), .tick(tick), .add_req(add_req),
    .load10(load10), .load205(load205), .count(count), .flash(flash),
    .expired(expired), .busy(busy), .req_drop(req_drop), .tick_lost(tick_lost)
  );

  always #5 clk = ~clk;

  // Reference model: pending requests as plain counts, one queued operation.
  int amts [4] = '{10, 180, 200, 550};
  int m_count, m_pend [4], m_ptr, m_busy, m_kind, m_val;
  bit m_tick, m_load, m_sel, m_drop, m_lost, m_flash, m_exp;

  task automatic model_reset();
    m_count = 0; m_ptr = 0; m_busy = 0; m_kind = 0; m_val = 0;
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
    m_tick = 0; m_load = 0; m_sel = 0; m_drop = 0; m_lost = 0;
    m_flash = 1; m_exp = 1;
  endtask

  task automatic model_edge(input bit t, input bit [3:0] a, input bit l10, input bit l205);
    bit gl, gt, keep;
    int ga, p;
    gl = 0; gt = 0; ga = -1;
    if (m_busy != 0) begin
      if (m_kind == 0)      m_count = m_val;
      else if (m_kind == 1) m_count = (m_count > 0) ? m_count - 1 : 0;
      else                  m_count = (m_count + m_val > 9999) ? 9999 : m_count + m_val;
      m_flash = (m_count < 200);
      m_exp   = (m_count == 0);
      m_busy  = 0;
    end else if (m_load) begin
      gl = 1; m_kind = 0; m_val = m_sel ? 205 : 10; m_busy = 1;
    end else if (m_tick) begin
      gt = 1; m_kind = 1; m_busy = 1;
    end else begin
      for (int k = 0; k < 4; k++)
        if (ga < 0 && m_pend[(m_ptr + k) % 4] > 0) ga = (m_ptr + k) % 4;
      if (ga >= 0) begin
        m_kind = 2; m_val = amts[ga]; m_ptr = (ga + 1) % 4; m_busy = 1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      p = gl ? 0 : m_pend[i] - ((ga == i) ? 1 : 0);
      if (a[i]) begin
        if (p + 1 > 3) m_drop = 1;
        else p = p + 1;
      end
      m_pend[i] = p;
    end
    keep = m_tick && !gt && !gl;
    if (t && keep) m_lost = 1;
    m_tick = keep || t;
    keep = m_load && !gl;
    if (l205) m_sel = 1;
    else if (l10 && !keep) m_sel = 0;
    m_load = keep || l10 || l205;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic chk_all();
    chk("count", int'(count), m_count);
    chk("flash", int'(flash), int'(m_flash));
    chk("expired", int'(expired), int'(m_exp));
    chk("busy", int'(busy), m_busy);
    chk("req_drop", int'(req_drop), int'(m_drop));
    chk("tick_lost", int'(tick_lost), int'(m_lost));
  endtask

  // Called at a negedge: drive, clock once, compare at the next negedge.
  task automatic step(input bit t, input bit [3:0] a, input bit l10, input bit l205);
    tick = t; add_req = a; load10 = l10; load205 = l205;
    @(posedge clk);
    model_edge(t, a, l10, l205);
    @(negedge clk);
    tick = 0; add_req = 4'd0; load10 = 0; load205 = 0;
    chk_all();
  endtask

  task automatic run_op(input bit t, input bit [3:0] a, input bit l10, input bit l205);
    step(t, a, l10, l205);
    step(0, 4'd0, 0, 0);
    step(0, 4'd0, 0, 0);
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset();
    reset = 1;
    #1;
    model_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_flash", int'(flash), 1);
    chk("rst_expired", int'(expired), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req_drop", int'(req_drop), 0);
    chk("rst_tick_lost", int'(tick_lost), 0);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single add, then a tick.
    run_op(0, 4'b1000, 0, 0);
    chk("add550", int'(count), 550);
    chk("add550_flash", int'(flash), 0);
    chk("add550_expired", int'(expired), 0);
    run_op(1, 4'd0, 0, 0);
    chk("tick549", int'(count), 549);

    // Saturation at the ceiling.
    for (int i = 0; i < 18; i++) run_op(0, 4'b1000, 0, 0);
    for (int i = 0; i < 9; i++) run_op(1, 4'd0, 0, 0);
    chk("at9990", int'(count), 9990);
    run_op(0, 4'b0001, 0, 0);
    chk("sat_add10", int'(count), 9999);
    run_op(0, 4'b1000, 0, 0);
    chk("sat_add550", int'(count), 9999);

    // All four adds at once: round-robin in order, then pointer wraps to 0.
    do_reset();
    step(0, 4'b1111, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 4'd0, 0, 0);
    chk("rr_total", int'(count), 940);
    step(0, 4'b1010, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 4'd0, 0, 0);
    chk("rr_wrap", int'(count), 1670);

    // Add strobes around a load: pend saturates and one strobe is dropped.
    do_reset();
    step(0, 4'b0010, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 4'b0010, 0, 0);
    chk("drop_flag", int'(req_drop), 1);
    for (int i = 0; i < 8; i++) step(0, 4'd0, 0, 0);

    // Both loads with tick and add pending: preset wins and wipes the rest.
    do_reset();
    step(1, 4'b0100, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 4'd0, 0, 0);
    chk("load205", int'(count), 205);
    chk("load205_flash", int'(flash), 0);
    do_reset();
    run_op(1, 4'd0, 0, 0);
    chk("tick_floor", int'(count), 0);
    chk("tick_floor_exp", int'(expired), 1);

    // Back-to-back ticks during an add, then reset in the middle of EXEC.
    do_reset();
    step(0, 4'b0001, 0, 0);
    step(1, 4'd0, 0, 0);
    step(1, 4'd0, 0, 0);
    chk("tick_lost_set", int'(tick_lost), 1);
    step(0, 4'b0100, 0, 0);
    chk("busy_before_rst", int'(busy), 1);
    do_reset();

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      bit t, l10, l205;
      bit [3:0] a;
      if ($urandom_range(0, 599) == 0) do_reset();
      t    = ($urandom_range(0, 7) == 0);
      a    = 4'($urandom) & 4'($urandom);
      l10  = ($urandom_range(0, 39) == 0);
      l205 = ($urandom_range(0, 39) == 0);
      step(t, a, l10, l205);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
